// File: rtl/dearv_pkg.sv
// Shared fetch-path types and constants.
// Entry layout and reset PC used by the fetch stage.
package dearv_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] RESET_PC =
    64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              fault;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } fetch_state_e;

  // Fetch targets are always word aligned.
  function automatic logic [XLEN-1:0] align_pc(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer between instruction bus and decode.
// Head is read straight from storage, so it is a register output.
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    cnt_q;

  // Storage write; cleared on reset so an empty head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!flush && enq) begin
      mem_q[wr_q] <= enq_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush beats enq/deq.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (enq) wr_q <= wr_q + AW'(1);
      if (deq) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(enq) - CW'(deq);
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC, prefetch FIFO, redirect.
// Halts after queuing an access fault until redirected.
module ifetch_unit
  import dearv_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = dearv_pkg::RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] iaddr,
  input  logic [63:0] idata,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic        out_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = $bits(fetch_entry_t);

  logic [63:0]  pc_q;
  logic [63:0]  pc_d;
  fetch_state_e st_q;
  fetch_state_e st_d;

  logic         enq;
  logic         deq;
  logic         room;
  logic [CW-1:0] cnt;
  fetch_entry_t wr_e;
  fetch_entry_t hd_e;
  logic [EW-1:0] hd_raw;
  logic         unused_bits;

  // Handshake and enqueue arbitration.
  always_comb begin
    room = cnt < CW'(FIFO_DEPTH);
    deq  = (cnt != '0) && out_ready && !redirect;
    enq  = (st_q == ST_RUN) && !redirect
           && (room || deq);
    wr_e = '{pc:    pc_q,
             inst:  idata[31:0],
             fault: ~pc_q[31]};
  end

  // Next PC and fetch state.
  always_comb begin
    pc_d = pc_q;
    st_d = st_q;
    if (redirect) begin
      pc_d = align_pc(redirect_pc);
      st_d = ST_RUN;
    end else begin
      unique case (st_q)
        ST_RUN: begin
          if (enq) begin
            if (wr_e.fault) begin
              st_d = ST_HALTED;
            end else begin
              pc_d = pc_q + 64'd4;
            end
          end
        end
        ST_HALTED: begin
          st_d = ST_HALTED;
        end
        default: begin
          st_d = ST_RUN;
        end
      endcase
    end
  end

  // PC and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      st_q <= ST_RUN;
    end else begin
      pc_q <= pc_d;
      st_q <= st_d;
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .enq      (enq),
    .enq_data (wr_e),
    .deq      (deq),
    .head     (hd_raw),
    .count    (cnt)
  );

  assign hd_e      = fetch_entry_t'(hd_raw);
  assign iaddr     = pc_q;
  assign out_valid = cnt != '0;
  assign out_inst  = hd_e.inst;
  assign out_pc    = hd_e.pc;
  assign out_fault = hd_e.fault;

  assign unused_bits = ^idata[63:32];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: reference scoreboard plus
// directed checks of reset, redirect, fault and wrap cases.
module tb_ifetch_unit;
  import dearv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] iaddr;
  logic [63:0] idata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_fault;

  bit flat;

  int n_vec = 0;
  int n_err = 0;

  fetch_entry_t sb[$];
  logic [63:0]  m_pc;
  bit           m_run;
  bit           armed = 1'b0;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .iaddr       (iaddr),
    .idata       (idata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_fault   (out_fault)
  );

  // Combinational memory: constant NOP or address-derived word.
  always_comb begin
    idata = {32'hCAFE_F00D,
             flat ? 32'h0000_0013
                  : (iaddr[31:0] ^ 32'h5A00_0013)};
  end

  function automatic logic [31:0] mem_word(
    input logic [63:0] a
  );
    return flat ? 32'h0000_0013 : (a[31:0] ^ 32'h5A00_0013);
  endfunction

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare against model, then predict next edge.
  always @(negedge clk) begin
    fetch_entry_t e;
    fetch_entry_t w;
    bit dq;
    int sz;
    if (armed) begin
      check("sb_valid", 64'(out_valid), 64'(sb.size() != 0));
      check("sb_iaddr", iaddr, m_pc);
    end
    if (rst) begin
      sb.delete();
      m_pc  = RESET_PC;
      m_run = 1'b1;
      armed = 1'b1;
    end else if (redirect) begin
      sb.delete();
      m_pc  = {redirect_pc[63:2], 2'b00};
      m_run = 1'b1;
    end else if (armed) begin
      sz = sb.size();
      dq = (sz != 0) && out_ready;
      if (dq) begin
        e = sb.pop_front();
        check("sb_pc",    out_pc,          e.pc);
        check("sb_inst",  64'(out_inst),   64'(e.inst));
        check("sb_fault", 64'(out_fault),  64'(e.fault));
      end
      if (m_run && (sz < 4 || dq)) begin
        w.pc    = m_pc;
        w.inst  = mem_word(m_pc);
        w.fault = ~m_pc[31];
        sb.push_back(w);
        if (w.fault) m_run = 1'b0;
        else         m_pc  = m_pc + 64'd4;
      end
    end
  end

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b1;
    flat        = 1'b1;

    // Reset state and first entries.
    step(2);
    rst = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_pc",    out_pc,         64'd0);
    check("rst_inst",  64'(out_inst),  64'd0);
    check("rst_fault", 64'(out_fault), 64'd0);
    check("rst_iaddr", iaddr,          64'h8000_0000);
    step();
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_pc0",   out_pc,         64'h8000_0000);
    check("t1_inst",  64'(out_inst),  64'h13);
    check("t1_fault", 64'(out_fault), 64'd0);
    step();
    check("t1_pc1", out_pc, 64'h8000_0004);
    step();
    check("t1_pc2", out_pc, 64'h8000_0008);

    // Backpressure fills the FIFO, then drains in order.
    flat      = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    step(10);
    check("t2_iaddr", iaddr,  64'h8000_0010);
    check("t2_head",  out_pc, 64'h8000_0000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_drain_v", 64'(out_valid), 64'd1);
      check("t2_drain", out_pc, 64'h8000_0004 + 64'(4 * i));
    end

    // Redirect while full drops the whole queue.
    out_ready = 1'b0;
    step(6);
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_0103;
    step();
    redirect = 1'b0;
    check("t3_valid0", 64'(out_valid), 64'd0);
    check("t3_iaddr",  iaddr,          64'h8000_0100);
    step();
    check("t3_valid1", 64'(out_valid), 64'd1);
    check("t3_pc",     out_pc,         64'h8000_0100);

    // Fault target: one fault entry, then halt.
    redirect    = 1'b1;
    redirect_pc = 64'h0000_1000;
    step();
    redirect = 1'b0;
    check("t4_valid0", 64'(out_valid), 64'd0);
    step();
    check("t4_valid1", 64'(out_valid), 64'd1);
    check("t4_pc",     out_pc,         64'h0000_1000);
    check("t4_fault",  64'(out_fault), 64'd1);
    check("t4_iaddr",  iaddr,          64'h0000_1000);
    step(5);
    check("t4_halt_v", 64'(out_valid), 64'd0);
    check("t4_halt_a", iaddr,          64'h0000_1000);
    redirect    = 1'b1;
    redirect_pc = 64'h8000_0000;
    step();
    redirect = 1'b0;
    step();
    check("t4_resume", out_pc,         64'h8000_0000);
    check("t4_rs_flt", 64'(out_fault), 64'd0);

    // Reset mid-stream wins over a simultaneous redirect.
    out_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_0040;
    step();
    redirect = 1'b0;
    step(3);
    check("t5_queued", 64'(out_valid), 64'd1);
    rst         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'h8000_0200;
    step();
    rst      = 1'b0;
    redirect = 1'b0;
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_iaddr", iaddr,          64'h8000_0000);
    step();
    check("t5_pc", out_pc, 64'h8000_0000);

    // PC wraps past the top of the address space.
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect = 1'b0;
    step();
    check("t6_pc_top", out_pc,         64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_flt0",   64'(out_fault), 64'd0);
    step();
    check("t6_pc_wrap", out_pc,         64'd0);
    check("t6_flt1",    64'(out_fault), 64'd1);
    step(3);
    check("t6_iaddr", iaddr,          64'd0);
    check("t6_halt",  64'(out_valid), 64'd0);

    // Random ready/redirect mix, scoreboard only.
    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      redirect  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)
        redirect_pc = 64'h0000_2000;
      else
        redirect_pc = {32'h0, 16'h8000, 16'($urandom)};
      step();
    end
    redirect  = 1'b0;
    out_ready = 1'b1;
    step(8);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
